// File: rtl/quad_step_decoder.sv
// Quadrature encoder front-end: 2-FF synchroniser, glitch filter and Gray-code step decoder.
// Optional build macro QDEC_ERR_CNT_EN adds a saturating illegal-transition counter (ERR_CNT, ERR_CLR).

module quad_step_decoder #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENC_A,
    input  logic       ENC_B,
    input  logic       EN,
`ifdef QDEC_ERR_CNT_EN
    input  logic       ERR_CLR,
    output logic [7:0] ERR_CNT,
`endif
    output logic       STEP,
    output logic       UP_DOWN,
    output logic       ERR
);

    typedef enum logic [1:0] {
        POS_00 = 2'b00,
        POS_01 = 2'b01,
        POS_11 = 2'b11,
        POS_10 = 2'b10
    } pos_t;

    localparam logic [8:0] FILT_N = 9'(FILTER_LEN);

    function automatic pos_t next_up(input pos_t p);
        pos_t n;
        n = POS_00;
        case (p)
            POS_00: n = POS_01;
            POS_01: n = POS_11;
            POS_11: n = POS_10;
            POS_10: n = POS_00;
        endcase
        return n;
    endfunction

    function automatic pos_t next_dn(input pos_t p);
        pos_t n;
        n = POS_00;
        case (p)
            POS_00: n = POS_10;
            POS_10: n = POS_11;
            POS_11: n = POS_01;
            POS_01: n = POS_00;
        endcase
        return n;
    endfunction

    logic [1:0] sync_q;
    logic [1:0] s_q;
    logic [1:0] s_prev_q;
    logic [7:0] cnt_q;
    pos_t       f_q;
    pos_t       f_old_q;
    logic       f_upd_q;
    logic       init_q;

    logic       s_steady;
    logic [8:0] samples;
    logic       accept;

    // samples = how many consecutive edges (including this one) have seen the current S.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        s_steady = (s_q == s_prev_q);
        samples  = s_steady ? ({1'b0, cnt_q} + 9'd2) : 9'd1;
        accept   = (s_q != f_q) && (samples >= FILT_N);
    end

    // NOTE: non-blocking assignments so each sync stage takes the previous stage's old value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q   <= 2'b00;
            s_q      <= 2'b00;
            s_prev_q <= 2'b00;
            cnt_q    <= 8'd0;
            f_q      <= POS_00;
            f_old_q  <= POS_00;
            f_upd_q  <= 1'b0;
        end else begin
            sync_q   <= {ENC_A, ENC_B};
            s_q      <= sync_q;
            s_prev_q <= s_q;
            f_upd_q  <= 1'b0;
            if (accept) begin
                f_old_q <= f_q;
                f_q     <= pos_t'(s_q);
                cnt_q   <= 8'd0;
                f_upd_q <= 1'b1;
            end else if ((s_q == f_q) || !s_steady) begin
                cnt_q <= 8'd0;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // First acceptance after reset only arms the decoder, so a resting non-00 encoder
    // does not produce a spurious step or error.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            init_q  <= 1'b0;
            STEP    <= 1'b0;
            ERR     <= 1'b0;
            UP_DOWN <= 1'b1;
        end else begin
            STEP <= 1'b0;
            ERR  <= 1'b0;
            if (f_upd_q) begin
                if (!init_q) begin
                    init_q <= 1'b1;
                end else if (EN) begin
                    if (f_q == next_up(f_old_q)) begin
                        STEP    <= 1'b1;
                        UP_DOWN <= 1'b1;
                    end else if (f_q == next_dn(f_old_q)) begin
                        STEP    <= 1'b1;
                        UP_DOWN <= 1'b0;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef QDEC_ERR_CNT_EN
    // Counts registered ERR pulses; a clear in the pulse's own cycle wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_CNT <= 8'd0;
        end else if (ERR_CLR) begin
            ERR_CNT <= 8'd0;
        end else if (ERR && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (FILTER_LEN = 4).
// Define QDEC_ERR_CNT_EN for both files to also exercise the error counter.
`timescale 1ns/1ps

module tb_quad_step_decoder;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       ENC_A;
    logic       ENC_B;
    logic       EN;
    logic       STEP;
    logic       UP_DOWN;
    logic       ERR;
`ifdef QDEC_ERR_CNT_EN
    logic       ERR_CLR;
    logic [7:0] ERR_CNT;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_step   = 0;
    int   n_err    = 0;
    int   n_both   = 0;
    logic ud_log[$];

    quad_step_decoder #(.FILTER_LEN(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ENC_A   (ENC_A),
        .ENC_B   (ENC_B),
        .EN      (EN),
`ifdef QDEC_ERR_CNT_EN
        .ERR_CLR (ERR_CLR),
        .ERR_CNT (ERR_CNT),
`endif
        .STEP    (STEP),
        .UP_DOWN (UP_DOWN),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (STEP) begin
            n_step++;
            ud_log.push_back(UP_DOWN);
        end
        if (ERR) n_err++;
        if (STEP && ERR) n_both++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_stats();
        n_step = 0;
        n_err  = 0;
        ud_log.delete();
    endtask

    task automatic set_ab(input logic [1:0] ab);
        {ENC_A, ENC_B} = ab;
    endtask

    task automatic test_reset();
        set_ab(2'b11);
        EN      = 1'b1;
        RESET_N = 1'b0;
        clear_stats();
        run(3);
        n_checks++; if (STEP !== 1'b0 || ERR !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: STEP=%b ERR=%b want 0 0", STEP, ERR); end
        n_checks++; if (UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL reset_updown: got %b want 1", UP_DOWN); end
        RESET_N = 1'b1;
        run(15);
        n_checks++; if (n_step !== 0 || n_err !== 0) begin n_fail++; $display("FAIL reset_first_accept: steps=%0d errs=%0d want 0 0", n_step, n_err); end
        n_checks++; if (UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL reset_updown_after: got %b want 1", UP_DOWN); end
    endtask

    task automatic test_up_rotation();
        int ones;
        set_ab(2'b10); run(10);
        set_ab(2'b00); run(10);
        clear_stats();
        set_ab(2'b01);
        run(6);
        n_checks++; if (STEP !== 1'b0 || n_step !== 0) begin n_fail++; $display("FAIL up_latency_early: STEP=%b steps=%0d want 0 0", STEP, n_step); end
        tick();
        n_checks++; if (STEP !== 1'b1 || UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL up_latency_edge7: STEP=%b UP_DOWN=%b want 1 1", STEP, UP_DOWN); end
        tick();
        n_checks++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL up_pulse_width: STEP=%b want 0", STEP); end
        run(2);
        set_ab(2'b11); run(10);
        set_ab(2'b10); run(10);
        set_ab(2'b00); run(10);
        n_checks++; if (n_step !== 4 || n_err !== 0) begin n_fail++; $display("FAIL up_count: steps=%0d errs=%0d want 4 0", n_step, n_err); end
        ones = 0;
        foreach (ud_log[i]) if (ud_log[i] === 1'b1) ones++;
        n_checks++; if (ones !== 4) begin n_fail++; $display("FAIL up_direction: up steps=%0d want 4", ones); end
    endtask

    task automatic test_down_reversal();
        logic exp_ud[5];
        exp_ud = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        clear_stats();
        set_ab(2'b10); run(10);
        set_ab(2'b11); run(10);
        set_ab(2'b01); run(10);
        set_ab(2'b11);
        run(6);
        n_checks++; if (STEP !== 1'b0 || UP_DOWN !== 1'b0) begin n_fail++; $display("FAIL rev_before: STEP=%b UP_DOWN=%b want 0 0", STEP, UP_DOWN); end
        tick();
        n_checks++; if (STEP !== 1'b1 || UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL rev_on_step: STEP=%b UP_DOWN=%b want 1 1", STEP, UP_DOWN); end
        run(3);
        set_ab(2'b10); run(10);
        n_checks++; if (ud_log.size() !== 5 || n_err !== 0) begin n_fail++; $display("FAIL down_count: steps=%0d errs=%0d want 5 0", ud_log.size(), n_err); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (ud_log[i] !== exp_ud[i]) begin n_fail++; $display("FAIL down_dir_%0d: got %b want %b", i, ud_log[i], exp_ud[i]); end
            end
        end
    endtask

    task automatic test_glitch();
        clear_stats();
        set_ab(2'b00); run(3);
        set_ab(2'b10); run(15);
        n_checks++; if (n_step !== 0 || n_err !== 0) begin n_fail++; $display("FAIL glitch: steps=%0d errs=%0d want 0 0", n_step, n_err); end
        for (int k = 0; k < 5; k++) begin
            set_ab(2'b00); run(2);
            set_ab(2'b10); run(2);
        end
        run(12);
        n_checks++; if (n_step !== 0 || n_err !== 0) begin n_fail++; $display("FAIL fast_toggle: steps=%0d errs=%0d want 0 0", n_step, n_err); end
    endtask

    task automatic test_illegal();
        set_ab(2'b11); run(10);
        set_ab(2'b01); run(10);
        set_ab(2'b00); run(10);
        n_checks++; if (UP_DOWN !== 1'b0) begin n_fail++; $display("FAIL illegal_pre_dir: got %b want 0", UP_DOWN); end
        clear_stats();
        set_ab(2'b11); run(10);
        n_checks++; if (n_err !== 1 || n_step !== 0) begin n_fail++; $display("FAIL illegal_jump: errs=%0d steps=%0d want 1 0", n_err, n_step); end
        n_checks++; if (UP_DOWN !== 1'b0) begin n_fail++; $display("FAIL illegal_dir_held: got %b want 0", UP_DOWN); end
    endtask

    task automatic test_en_gating();
        clear_stats();
        EN = 1'b0;
        set_ab(2'b10); run(10);
        set_ab(2'b01); run(10);
        set_ab(2'b00); run(10);
        n_checks++; if (n_step !== 0 || n_err !== 0) begin n_fail++; $display("FAIL en_off: steps=%0d errs=%0d want 0 0", n_step, n_err); end
        n_checks++; if (UP_DOWN !== 1'b0) begin n_fail++; $display("FAIL en_off_dir: got %b want 0", UP_DOWN); end
        EN = 1'b1;
        set_ab(2'b01); run(10);
        n_checks++; if (n_step !== 1 || n_err !== 0 || UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL en_on: steps=%0d errs=%0d UP_DOWN=%b want 1 0 1", n_step, n_err, UP_DOWN); end
    endtask

    task automatic test_async_reset();
        set_ab(2'b00); run(10);
        n_checks++; if (UP_DOWN !== 1'b0) begin n_fail++; $display("FAIL areset_pre_dir: got %b want 0", UP_DOWN); end
        set_ab(2'b01);
        run(5);
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++; if (STEP !== 1'b0 || ERR !== 1'b0 || UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL areset_immediate: STEP=%b ERR=%b UP_DOWN=%b want 0 0 1", STEP, ERR, UP_DOWN); end
        run(2);
        RESET_N = 1'b1;
        clear_stats();
        run(15);
        n_checks++; if (n_step !== 0 || n_err !== 0) begin n_fail++; $display("FAIL areset_rearm: steps=%0d errs=%0d want 0 0", n_step, n_err); end
        set_ab(2'b11); run(10);
        n_checks++; if (n_step !== 1 || UP_DOWN !== 1'b1) begin n_fail++; $display("FAIL areset_step: steps=%0d UP_DOWN=%b want 1 1", n_step, UP_DOWN); end
    endtask

`ifdef QDEC_ERR_CNT_EN
    task automatic test_err_cnt();
        n_checks++; if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL errcnt_start: got %0d want 0", ERR_CNT); end
        clear_stats();
        for (int j = 0; j < 300; j++) begin
            set_ab((j % 2 == 0) ? 2'b00 : 2'b11);
            run(10);
            if (j == 9) begin
                n_checks++; if (ERR_CNT !== 8'd10) begin n_fail++; $display("FAIL errcnt_10: got %0d want 10", ERR_CNT); end
            end
        end
        n_checks++; if (ERR_CNT !== 8'd255 || n_err !== 300) begin n_fail++; $display("FAIL errcnt_sat: cnt=%0d errs=%0d want 255 300", ERR_CNT, n_err); end
        set_ab(2'b00);
        run(7);
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL errclr_pulse: ERR=%b want 1", ERR); end
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        n_checks++; if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL errclr_priority: got %0d want 0", ERR_CNT); end
        run(3);
        set_ab(2'b11); run(10);
        n_checks++; if (ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL errcnt_after_clr: got %0d want 1", ERR_CNT); end
    endtask
`endif

    initial begin
        RESET_N = 1'b0;
        EN      = 1'b1;
        set_ab(2'b11);
`ifdef QDEC_ERR_CNT_EN
        ERR_CLR = 1'b0;
`endif
        test_reset();
        test_up_rotation();
        test_down_reversal();
        test_glitch();
        test_illegal();
        test_en_gating();
        test_async_reset();
`ifdef QDEC_ERR_CNT_EN
        test_err_cnt();
`endif
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL step_err_overlap: cycles=%0d want 0", n_both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
